// File: rtl/uart_bridge_pkg.sv
// Shared types and constants for the UART echo bridge: FSM encoding, transform
// modes, ASCII letter ranges and the outgoing-byte transform.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ECHO = 2'd0;
    localparam logic [1:0] MODE_INV  = 2'd1;
    localparam logic [1:0] MODE_INC  = 2'd2;
    localparam logic [1:0] MODE_CASE = 2'd3;

    localparam logic [7:0] ASCII_UC_LO = 8'h41;
    localparam logic [7:0] ASCII_UC_HI = 8'h5A;
    localparam logic [7:0] ASCII_LC_LO = 8'h61;
    localparam logic [7:0] ASCII_LC_HI = 8'h7A;

    // Works on a 32-bit carrier so one function serves any DATA_BITS up to 32;
    // results are masked back to 'bits' so NOT and +1 wrap at the char width.
    function automatic logic [31:0] xform(input logic [31:0] d,
                                          input logic [1:0]  mode,
                                          input int unsigned bits);
        logic [31:0] mask;
        logic [31:0] r;
        logic        is_alpha;
        mask     = ~(32'hFFFF_FFFF << bits);
        is_alpha = ((d[7:0] >= ASCII_UC_LO) && (d[7:0] <= ASCII_UC_HI)) ||
                   ((d[7:0] >= ASCII_LC_LO) && (d[7:0] <= ASCII_LC_HI));
        r = d;
        case (mode)
            MODE_ECHO: r = d;
            MODE_INV:  r = ~d & mask;
            MODE_INC:  r = (d + 32'd1) & mask;
            MODE_CASE: if (bits == 8 && is_alpha) r = d ^ 32'h0000_0020;
            default:   r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_echo_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO with extra-MSB pointers and a
// registered occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [WIDTH-1:0]         o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      r_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + ONE;
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + ONE;
                2'b01:   r_level <= r_level - ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_level = r_level;
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_echo_bridge.sv
// Buffered UART loopback: received bytes queue in a FIFO and are handed to the
// transmitter one at a time, optionally transformed, with debug LEDs/counters.
module uart_echo_bridge
    import uart_bridge_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_BITS   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_rx_done,
    input  logic [DATA_BITS-1:0]          i_rx_data,
    input  logic                          i_tx_done,
    input  logic [1:0]                    i_mode,
    output logic                          o_tx_start,
    output logic [DATA_BITS-1:0]          o_tx_data,
    output logic [DATA_BITS-1:0]          o_leds,
    output logic [CNT_BITS-1:0]           o_rx_count,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    state_t                 r_state;
    state_t                 w_next;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_empty;
    logic [DATA_BITS-1:0]   w_head;
    logic [DATA_BITS-1:0]   w_xf;
    logic                   r_tx_start;
    logic [DATA_BITS-1:0]   r_tx_data;
    logic [DATA_BITS-1:0]   r_leds;
    logic [CNT_BITS-1:0]    r_rx_count;
    logic                   r_overflow;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push = i_rx_done && (!w_full || w_pop);
    assign w_drop = i_rx_done && w_full && !w_pop;
    assign w_xf   = DATA_BITS'(xform(32'(w_head), i_mode, DATA_BITS));

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_rx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level),
        .o_head  (w_head)
    );

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = START;
                end
            end
            START:     w_next = WAIT_DONE;
            WAIT_DONE: if (i_tx_done) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_leds     <= '0;
            r_rx_count <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tx_start <= w_pop;
            if (w_pop)     r_tx_data  <= w_xf;
            if (i_rx_done) r_leds     <= i_rx_data;
            if (i_rx_done) r_rx_count <= r_rx_count + CNT_BITS'(1);
            if (w_drop)    r_overflow <= 1'b1;
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_leds     = r_leds;
    assign o_rx_count = r_rx_count;
    assign o_overflow = r_overflow;

endmodule

// File: tb/tb_uart_echo_bridge.sv
// Scoreboard bench for uart_echo_bridge (depth 4): expected bytes are queued as
// stimulus is driven and compared against the start pulses the DUT produces.
module tb_uart_echo_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_rx_done;
    logic [7:0]  i_rx_data;
    logic        i_tx_done;
    logic [1:0]  i_mode;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic [7:0]  o_leds;
    logic [15:0] o_rx_count;
    logic        o_overflow;
    logic [2:0]  o_fifo_level;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         exp_cnt = 0;
    int         peak = 0;
    bit         tx_auto = 1'b0;
    int         tx_delay = 3;

    uart_echo_bridge #(
        .DATA_BITS  (8),
        .FIFO_DEPTH (4),
        .CNT_BITS   (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_tx_done    (i_tx_done),
        .i_mode       (i_mode),
        .o_tx_start   (o_tx_start),
        .o_tx_data    (o_tx_data),
        .o_leds       (o_leds),
        .o_rx_count   (o_rx_count),
        .o_overflow   (o_overflow),
        .o_fifo_level (o_fifo_level)
    );

    always #5 clk = ~clk;

    // Observe outputs mid-cycle.
    always @(negedge clk) begin
        if (o_tx_start === 1'b1) obs_q.push_back(o_tx_data);
        if (int'(o_fifo_level) > peak) peak = int'(o_fifo_level);
    end

    // Transmitter model: done pulse tx_delay cycles after each start.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_auto && o_tx_start === 1'b1) begin
                repeat (tx_delay) @(negedge clk);
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, got running want finished");
        $fatal(1);
    end

    task automatic pulse_rx(input logic [7:0] d);
        i_rx_data = d;
        i_rx_done = 1'b1;
        exp_cnt++;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic do_reset();
        tx_auto   = 1'b0;
        reset     = 1'b1;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (o_tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", o_tx_start); end
        n_vec++; if (o_tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", o_tx_data); end
        n_vec++; if (o_leds !== 8'h00) begin n_err++; $display("FAIL reset_leds: got %h want 00", o_leds); end
        n_vec++; if (o_rx_count !== 16'h0) begin n_err++; $display("FAIL reset_count: got %0d want 0", o_rx_count); end
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", o_overflow); end
        n_vec++; if (o_fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", o_fifo_level); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        i_mode = 2'd0; tx_auto = 1'b1; tx_delay = 20;
        pulse_rx(8'h41);
        exp_q.push_back(8'h41);
        n_vec++; if (o_leds !== 8'h41) begin n_err++; $display("FAIL single_leds: got %h want 41", o_leds); end
        n_vec++; if (o_rx_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d want 1", o_rx_count); end
        n_vec++; if (o_fifo_level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", o_fifo_level); end
        n_vec++; if (o_tx_start !== 1'b0) begin n_err++; $display("FAIL single_early_start: got %b want 0", o_tx_start); end
        @(negedge clk);
        n_vec++; if (o_tx_start !== 1'b1) begin n_err++; $display("FAIL single_start_k2: got %b want 1", o_tx_start); end
        n_vec++; if (o_tx_data !== 8'h41) begin n_err++; $display("FAIL single_data: got %h want 41", o_tx_data); end
        repeat (30) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL single_nstart: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL single_sb: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_modes();
        logic [7:0] td [6] = '{8'h61, 8'h30, 8'h0F, 8'hFF, 8'h5A, 8'h7B};
        logic [1:0] tm [6] = '{2'd3,  2'd3,  2'd1,  2'd2,  2'd3,  2'd3};
        logic [7:0] te [6] = '{8'h41, 8'h30, 8'hF0, 8'h00, 8'h7A, 8'h7B};
        tx_auto = 1'b1; tx_delay = 3;
        for (int i = 0; i < 6; i++) begin
            i_mode = tm[i];
            pulse_rx(td[i]);
            exp_q.push_back(te[i]);
            repeat (12) @(negedge clk);
        end
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL modes_nstart: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL modes_sb: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        // Mode change while the byte is in flight.
        tx_auto = 1'b0;
        i_mode = 2'd1;
        pulse_rx(8'h0F);
        exp_q.push_back(8'hF0);
        @(negedge clk);
        i_mode = 2'd2;
        repeat (3) @(negedge clk);
        n_vec++; if (o_tx_data !== 8'hF0) begin n_err++; $display("FAIL mode_hold: got %h want F0", o_tx_data); end
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        i_mode = 2'd0;
        repeat (4) @(negedge clk);
        n_vec++; if (o_tx_data !== 8'hF0) begin n_err++; $display("FAIL mode_hold_after: got %h want F0", o_tx_data); end
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mode_hold_nstart: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL mode_hold_sb: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_burst();
        i_mode = 2'd0; tx_auto = 1'b1; tx_delay = 20; peak = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_rx(8'h10 + 8'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
        repeat (150) @(negedge clk);
        n_vec++; if (peak != 4 && peak != 5) begin n_err++; $display("FAIL burst_peak: got %0d want 4 or 5", peak); end
        n_vec++; if (obs_q.size() != 5) begin n_err++; $display("FAIL burst_nstart: got %0d want 5", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL burst_sb: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_overflow();
        do_reset();
        i_mode = 2'd0;
        for (int i = 0; i < 6; i++) begin
            pulse_rx(8'h20 + 8'(i));
            if (i < 5) exp_q.push_back(8'h20 + 8'(i));
        end
        @(negedge clk);
        n_vec++; if (o_fifo_level !== 3'd4) begin n_err++; $display("FAIL ovf_level: got %0d want 4", o_fifo_level); end
        n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
        n_vec++; if (int'(o_rx_count) != exp_cnt) begin n_err++; $display("FAIL ovf_count: got %0d want %0d", o_rx_count, exp_cnt); end
        n_vec++; if (obs_q.size() != 1) begin n_err++; $display("FAIL ovf_inflight: got %0d want 1", obs_q.size()); end
        tx_auto = 1'b1; tx_delay = 4;
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        repeat (60) @(negedge clk);
        n_vec++; if (obs_q.size() != 5) begin n_err++; $display("FAIL ovf_nstart: got %0d want 5", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL ovf_sb: got %h want %h", o, e); end
        end
        n_vec++; if (o_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_full_push_pop();
        do_reset();
        i_mode = 2'd0;
        for (int i = 0; i < 6; i++) exp_q.push_back(8'h30 + 8'(i));
        for (int i = 0; i < 5; i++) pulse_rx(8'h30 + 8'(i));
        n_vec++; if (o_fifo_level !== 3'd4) begin n_err++; $display("FAIL fpp_full: got %0d want 4", o_fifo_level); end
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        tx_auto = 1'b1; tx_delay = 3;
        pulse_rx(8'h35);
        n_vec++; if (o_fifo_level !== 3'd4) begin n_err++; $display("FAIL fpp_level: got %0d want 4", o_fifo_level); end
        n_vec++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL fpp_overflow: got %b want 0", o_overflow); end
        repeat (60) @(negedge clk);
        n_vec++; if (obs_q.size() != 6) begin n_err++; $display("FAIL fpp_nstart: got %0d want 6", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            logic [7:0] e, o;
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_vec++; if (o !== e) begin n_err++; $display("FAIL fpp_sb: got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_mode = 2'd0;
        pulse_rx(8'h55);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0; exp_q.delete(); obs_q.delete();
        n_vec++; if (o_tx_data !== 8'h00) begin n_err++; $display("FAIL rmid_tx_data: got %h want 00", o_tx_data); end
        n_vec++; if (o_leds !== 8'h00) begin n_err++; $display("FAIL rmid_leds: got %h want 00", o_leds); end
        n_vec++; if (o_rx_count !== 16'd0) begin n_err++; $display("FAIL rmid_count: got %0d want 0", o_rx_count); end
        n_vec++; if (o_fifo_level !== 3'd0) begin n_err++; $display("FAIL rmid_level: got %0d want 0", o_fifo_level); end
        i_tx_done = 1'b1;
        @(negedge clk);
        i_tx_done = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++; if (obs_q.size() != 0) begin n_err++; $display("FAIL rmid_stray_start: got %0d want 0", obs_q.size()); end
        tx_auto = 1'b1; tx_delay = 3;
        pulse_rx(8'h66);
        exp_q.push_back(8'h66);
        n_vec++; if (o_fifo_level !== 3'd1) begin n_err++; $display("FAIL rmid_level1: got %0d want 1", o_fifo_level); end
        n_vec++; if (int'(o_rx_count) != exp_cnt) begin n_err++; $display("FAIL rmid_count1: got %0d want %0d", o_rx_count, exp_cnt); end
        @(negedge clk);
        n_vec++; if (o_tx_start !== 1'b1) begin n_err++; $display("FAIL rmid_start_k2: got %b want 1", o_tx_start); end
        n_vec++; if (o_tx_data !== 8'h66) begin n_err++; $display("FAIL rmid_data: got %h want 66", o_tx_data); end
        repeat (10) @(negedge clk);
        n_vec++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rmid_nstart: got %0d want %0d", obs_q.size(), exp_q.size()); end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        i_tx_done = 1'b0;
        i_mode    = 2'd0;
        @(negedge clk);
        test_reset();
        test_single();
        test_modes();
        test_burst();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
